// File: rtl/line_derotator.sv
// Receiver-side line derotator: buffers each BT.656 line in a ping-pong RAM and
// replays it one line later with the active video rotated back by the latched cut.
module line_derotator (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] data_in,
  input  logic       H,
  input  logic       V,
  input  logic [7:0] raw_cut_position,
  input  logic       cut_valid,
  output logic [9:0] data_out,
  output logic       H_out,
  output logic       V_out,
  output logic       data_valid,
  output logic       line_error
);

  localparam int LINE_SAMPLES   = 1716;
  localparam int BLANK_SAMPLES  = 276;
  localparam int ACTIVE_SAMPLES = 1440;
  localparam int CUT_MOD        = 180;

  typedef enum logic [1:0] {
    WAIT_EAV,
    FILL,
    RUN
  } state_t;

  state_t      state_q, state_d;
  logic        h_q;
  logic        eav_edge, h_fall;
  logic [11:0] cnt_q, cur_cnt, cnt_d;
  logic [10:0] pos;
  logic        bank_q, wr_bank, rd_bank;
  logic        wr_en;
  logic [9:0]  cut_off_q [2];
  logic [7:0]  cut_q;
  logic [9:0]  cut_off;
  logic [10:0] rd_off;
  logic [10:0] rd_addr;
  logic        rd_active;
  logic [11:0] rd_q;
  logic        rd_valid_q;

  logic [11:0] mem0 [LINE_SAMPLES];
  logic [11:0] mem1 [LINE_SAMPLES];

  assign eav_edge = H & ~h_q;
  assign h_fall   = ~H & h_q;

  // cnt counts words of the current line and saturates one past a full line,
  // so an over-long line is still distinguishable from a correct one.
  assign cur_cnt = eav_edge ? 12'd0 : cnt_q;
  assign cnt_d   = (cur_cnt == 12'(LINE_SAMPLES + 1)) ? cur_cnt : cur_cnt + 12'd1;
  assign pos     = (cur_cnt >= 12'(LINE_SAMPLES - 1)) ? 11'(LINE_SAMPLES - 1) : cur_cnt[10:0];

  assign wr_bank = eav_edge ? ~bank_q : bank_q;
  assign rd_bank = ~wr_bank;

  // NOTE: every variable driven in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_EAV: if (eav_edge) state_d = FILL;
      FILL:     if (eav_edge) state_d = RUN;
      RUN:      state_d = RUN;
      default:  state_d = WAIT_EAV;
    endcase
  end

  // Writing starts on the edge cycle itself, and words past a full line are dropped.
  assign wr_en     = (state_d != WAIT_EAV) && (cur_cnt < 12'(LINE_SAMPLES));
  assign rd_active = (state_d == RUN);

  assign cut_q   = (raw_cut_position >= 8'(CUT_MOD)) ? raw_cut_position - 8'(CUT_MOD)
                                                     : raw_cut_position;
  assign cut_off = {cut_q, 2'b00};

  // Active read index is (pos - blank - off) mod ACTIVE, split into its two
  // non-negative cases so no signed arithmetic is needed.
  always_comb begin
    rd_off  = {1'b0, cut_off_q[rd_bank]};
    rd_addr = pos;
    if (pos >= 11'(BLANK_SAMPLES)) begin
      if (pos >= 11'(BLANK_SAMPLES) + rd_off) begin
        rd_addr = pos - rd_off;
      end else begin
        rd_addr = pos + (11'(ACTIVE_SAMPLES) - rd_off);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= WAIT_EAV;
      h_q          <= 1'b1;
      cnt_q        <= '0;
      bank_q       <= 1'b0;
      cut_off_q[0] <= '0;
      cut_off_q[1] <= '0;
      rd_valid_q   <= 1'b0;
      data_out     <= '0;
      H_out        <= 1'b0;
      V_out        <= 1'b0;
      data_valid   <= 1'b0;
      line_error   <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= H;
      cnt_q   <= cnt_d;
      bank_q  <= wr_bank;
      if (h_fall) begin
        cut_off_q[wr_bank] <= (V || !cut_valid) ? 10'd0 : cut_off;
      end
      rd_valid_q <= rd_active;
      data_valid <= rd_valid_q;
      data_out   <= rd_valid_q ? rd_q[11:2] : 10'd0;
      H_out      <= rd_valid_q & rd_q[1];
      V_out      <= rd_valid_q & rd_q[0];
      line_error <= eav_edge && (state_q != WAIT_EAV) && (cnt_q != 12'(LINE_SAMPLES));
    end
  end

  // NOTE: the line RAM has no reset; its contents are only observed after being written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_bank) mem1[pos] <= {data_in, H, V};
      else         mem0[pos] <= {data_in, H, V};
    end
    rd_q <= rd_bank ? mem1[rd_addr] : mem0[rd_addr];
  end

endmodule

// File: tb/tb_line_derotator.sv
// Scoreboard bench for line_derotator: a behavioural scrambler feeds the DUT and
// the original line is expected back one line later.
module tb_line_derotator;

  localparam int LINE   = 1716;
  localparam int BLANK  = 276;
  localparam int ACTIVE = 1440;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] data_in = '0;
  logic       H = 1'b0;
  logic       V = 1'b0;
  logic [7:0] raw_cut_position = '0;
  logic       cut_valid = 1'b0;
  logic [9:0] data_out;
  logic       H_out, V_out, data_valid, line_error;

  always #5 clk = ~clk;

  line_derotator dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .data_in          (data_in),
    .H                (H),
    .V                (V),
    .raw_cut_position (raw_cut_position),
    .cut_valid        (cut_valid),
    .data_out         (data_out),
    .H_out            (H_out),
    .V_out            (V_out),
    .data_valid       (data_valid),
    .line_error       (line_error)
  );

  typedef struct packed {
    logic [9:0] d;
    logic       h;
    logic       v;
  } word_t;

  typedef struct {
    word_t w;
    int    line;
    int    pos;
  } exp_t;

  // off is the hand-computed rotation for the given raw cut byte.
  typedef struct {
    int len;
    int raw;
    int off;
    bit cv;
    bit v;
    int pat;
  } line_cfg_t;

  exp_t      sb [$];
  int        n_vec = 0;
  int        n_err = 0;
  bit        draining = 1'b0;
  word_t     orig_cur  [LINE];
  word_t     orig_prev [LINE];
  word_t     drv [3][LINE];
  int        len_prev = LINE;
  line_cfg_t tbl [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n) begin
      if (data_valid) begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check($sformatf("out line %0d pos %0d", e.line, e.pos),
                {20'd0, data_out, H_out, V_out}, {20'd0, e.w});
        end else if (!draining) begin
          check("spurious data_valid", {31'd0, data_valid}, 32'd0);
        end
      end else begin
        check("idle outputs", {20'd0, data_out, H_out, V_out}, 32'd0);
      end
    end
  end

  // Expected output of line n-1, replayed over the length of input line n.
  task automatic push_expected(input int n, input int len);
    exp_t e;
    int   pe, eff;
    eff = (len_prev > LINE) ? LINE : len_prev;
    for (int p = 0; p < len; p++) begin
      pe = (p > LINE - 1) ? LINE - 1 : p;
      if (pe < eff || n < 3) e.w = orig_prev[pe];
      else                   e.w = drv[n % 3][pe];  // stale word left by line n-3
      e.line = n - 1;
      e.pos  = p;
      sb.push_back(e);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " data_out"},   {22'd0, data_out},   32'd0);
    check({tag, " H_out"},      {31'd0, H_out},      32'd0);
    check({tag, " V_out"},      {31'd0, V_out},      32'd0);
    check({tag, " data_valid"}, {31'd0, data_valid}, 32'd0);
    check({tag, " line_error"}, {31'd0, line_error}, 32'd0);
  endtask

  task automatic drive_line(input int n, input line_cfg_t c, input int stop_at);
    word_t s [LINE];
    word_t w;
    int    m;
    if (n >= 1) push_expected(n, c.len);
    for (int p = 0; p < LINE; p++) begin
      w.v = c.v;
      if (p < BLANK) begin
        w.h = 1'b1;
        w.d = (c.pat == 0) ? 10'(p) : 10'((p * 3 + n * 11) & 'h3ff);
      end else begin
        m = p - BLANK;
        w.h = 1'b0;
        case (c.pat)
          0:       w.d = 10'(p);
          1:       w.d = 10'(m);
          default: w.d = 10'((m * 5 + n * 29 + 7) & 'h3ff);
        endcase
      end
      orig_cur[p] = w;
    end
    // Behavioural scrambler: out[k] = orig[(k + off) mod ACTIVE].
    for (int p = 0; p < LINE; p++) begin
      if (p < BLANK) s[p] = orig_cur[p];
      else           s[p] = orig_cur[BLANK + ((p - BLANK) + c.off) % ACTIVE];
      drv[n % 3][p] = s[p];
    end
    for (int p = 0; p < c.len; p++) begin
      if (p < LINE) begin
        w = s[p];
      end else begin
        w.d = 10'(((p * 7) ^ 'h155) & 'h3ff);
        w.h = 1'b0;
        w.v = c.v;
      end
      data_in          = w.d;
      H                = w.h;
      V                = w.v;
      raw_cut_position = (p == BLANK) ? 8'(c.raw) : 8'((p * 13) & 'hff);
      cut_valid        = (p == BLANK) ? c.cv : p[0];
      if (p == stop_at) begin
        #2;
        check("active before reset", {31'd0, data_valid}, 32'd1);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("mid-line reset");
        sb.delete();
        return;
      end
      @(negedge clk);
      if (p == 0) begin
        check($sformatf("line_error at line %0d", n), {31'd0, line_error},
              (n >= 1 && len_prev != LINE) ? 32'd1 : 32'd0);
        if (n <= 1) check($sformatf("data_valid low at edge, line %0d", n),
                          {31'd0, data_valid}, 32'd0);
      end
      if (p == 1) begin
        check($sformatf("line_error pulse width, line %0d", n), {31'd0, line_error}, 32'd0);
        if (n == 1) check("data_valid rise at edge+2", {31'd0, data_valid}, 32'd1);
      end
    end
    orig_prev = orig_cur;
    len_prev  = c.len;
  endtask

  task automatic idle(input int cycles);
    data_in = '0;
    H       = 1'b0;
    V       = 1'b0;
    raw_cut_position = '0;
    cut_valid = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    //          len   raw  off  cv    v     pat
    tbl[0]  = '{LINE,   0,   0, 1'b1, 1'b0, 0};
    tbl[1]  = '{LINE,   0,   0, 1'b1, 1'b0, 0};
    tbl[2]  = '{LINE,   1,   4, 1'b1, 1'b0, 1};
    tbl[3]  = '{LINE, 200,  80, 1'b1, 1'b0, 2};
    tbl[4]  = '{LINE, 179, 716, 1'b1, 1'b0, 2};
    tbl[5]  = '{LINE, 180,   0, 1'b1, 1'b0, 2};
    tbl[6]  = '{LINE,  37,   0, 1'b1, 1'b1, 2};
    tbl[7]  = '{LINE,  37,   0, 1'b0, 1'b0, 2};
    tbl[8]  = '{1700,   0,   0, 1'b1, 1'b0, 2};
    tbl[9]  = '{LINE,   7,  28, 1'b1, 1'b0, 2};
    tbl[10] = '{1800,   0,   0, 1'b1, 1'b0, 2};
    tbl[11] = '{LINE, 255, 300, 1'b1, 1'b0, 2};
    tbl[12] = '{LINE,   0,   0, 1'b1, 1'b0, 2};

    repeat (3) @(negedge clk);
    check_reset_outputs("power-on reset");
    reset_n = 1'b1;
    idle(5);

    for (int n = 0; n < 5; n++) drive_line(n, tbl[n], -1);
    drive_line(5, tbl[5], 900);

    idle(3);
    reset_n = 1'b1;
    idle(5);
    len_prev = LINE;

    for (int n = 0; n < 13; n++) drive_line(n, tbl[n], -1);
    draining = 1'b1;
    repeat (4) @(negedge clk);
    check("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
